// File: rtl/cpu_alu_pkg.sv
// Shared ALU definitions: opcode constants and the sequential divider's state encoding.
package cpu_alu_pkg;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_MUL = 5'b01110;
    localparam logic [4:0] ALU_DIV = 5'b01111;

    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_PREP = 3'd1,
        DIV_ITER = 3'd2,
        DIV_FIX  = 3'd3,
        DIV_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/seq_div_unit_if.sv
// Request/result bundle of the sequential divider; master issues divides, slave is the unit.
interface seq_div_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic [2*WIDTH-1:0]   c_data_out;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder, c_data_out
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder, c_data_out
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, subtract D from R when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH:0]   r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] r_diff;
    logic           fits;

    assign r_shift = {r_in[WIDTH-1:0], q_in[WIDTH-1]};
    assign r_diff  = r_shift - {1'b0, d_in};
    // A set top bit means the true shifted value exceeds any WIDTH-bit divisor.
    assign fits    = r_in[WIDTH] | (r_shift >= {1'b0, d_in});
    assign r_out   = fits ? r_diff : r_shift;
    assign q_out   = {q_in[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_div_unit.sv
// Multi-cycle restoring divider, signed/unsigned, with divide-by-zero flag.
// Result layout on c_data_out is {remainder, quotient}.
module seq_div_unit
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         Clock,
    input  logic         clear,
    seq_div_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    dvd_q, dvd_d;
    logic [WIDTH-1:0]    dvs_q, dvs_d;
    logic                sgn_q, sgn_d;
    logic [WIDTH:0]      rem_q, rem_d;
    logic [WIDTH-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0]    mag_q, mag_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;
    logic [WIDTH-1:0]    q_out_q, q_out_d;
    logic [WIDTH-1:0]    r_out_q, r_out_d;

    logic [WIDTH:0]      step_r;
    logic [WIDTH-1:0]    step_q;
    logic                dvd_neg;
    logic                dvs_neg;
    logic [WIDTH-1:0]    dvd_mag;
    logic [WIDTH-1:0]    dvs_mag;
    logic                divisor_zero;
    logic                last_step;
    logic [WIDTH-1:0]    q_fix;
    logic [WIDTH-1:0]    r_fix;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_in  (rem_q),
        .q_in  (quo_q),
        .d_in  (mag_q),
        .r_out (step_r),
        .q_out (step_q)
    );

    // Magnitudes are unsigned WIDTH bits, so |MIN| keeps its bit pattern.
    assign dvd_neg      = sgn_q & dvd_q[WIDTH-1];
    assign dvs_neg      = sgn_q & dvs_q[WIDTH-1];
    assign dvd_mag      = dvd_neg ? (~dvd_q + 1'b1) : dvd_q;
    assign dvs_mag      = dvs_neg ? (~dvs_q + 1'b1) : dvs_q;
    assign divisor_zero = (dvs_q == '0);
    assign last_step    = (cnt_q == CNT_W'(WIDTH - 1));

    // Truncation toward zero: remainder follows the dividend's sign.
    assign q_fix = (dvd_neg ^ dvs_neg) ? (~quo_q + 1'b1) : quo_q;
    assign r_fix = dvd_neg ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (bus.start) state_d = DIV_PREP;
            DIV_PREP: state_d = divisor_zero ? DIV_DONE : DIV_ITER;
            DIV_ITER: if (last_step) state_d = DIV_FIX;
            DIV_FIX:  state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        mag_d   = mag_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (bus.start) begin
                    dvd_d  = bus.dividend;
                    dvs_d  = bus.divisor;
                    sgn_d  = bus.is_signed;
                    dbz_d  = 1'b0;
                    busy_d = 1'b1;
                end
            end
            DIV_PREP: begin
                if (divisor_zero) begin
                    q_out_d = '1;
                    r_out_d = dvd_q;
                    dbz_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    rem_d = '0;
                    quo_d = dvd_mag;
                    mag_d = dvs_mag;
                    cnt_d = '0;
                end
            end
            DIV_ITER: begin
                rem_d = step_r;
                quo_d = step_q;
                cnt_d = cnt_q + CNT_W'(1);
            end
            DIV_FIX: begin
                q_out_d = q_fix;
                r_out_d = r_fix;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            mag_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            q_out_q <= '0;
            r_out_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            mag_q   <= mag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.quotient    = q_out_q;
    assign bus.remainder   = r_out_q;
    assign bus.c_data_out  = {r_out_q, q_out_q};

endmodule

// File: tb/tb_seq_div_unit.sv
// Directed bench for seq_div_unit: 32-bit and 8-bit instances, hand-computed results.
module tb_seq_div_unit;

    logic clk = 1'b0;
    logic clear;

    always #5 clk = ~clk;

    seq_div_unit_if #(.WIDTH(32)) bus32 ();
    seq_div_unit_if #(.WIDTH(8))  bus8  ();

    seq_div_unit #(.WIDTH(32)) u_dut32 (
        .Clock (clk),
        .clear (clear),
        .bus   (bus32)
    );

    seq_div_unit #(.WIDTH(8)) u_dut8 (
        .Clock (clk),
        .clear (clear),
        .bus   (bus8)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit w8, input logic s, input logic sm,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            bus8.start     = s;
            bus8.is_signed = sm;
            bus8.dividend  = a[7:0];
            bus8.divisor   = b[7:0];
        end else begin
            bus32.start     = s;
            bus32.is_signed = sm;
            bus32.dividend  = a;
            bus32.divisor   = b;
        end
    endtask

    function automatic logic [31:0] get_q(input bit w8);
        return w8 ? {24'h0, bus8.quotient} : bus32.quotient;
    endfunction

    function automatic logic [31:0] get_r(input bit w8);
        return w8 ? {24'h0, bus8.remainder} : bus32.remainder;
    endfunction

    function automatic logic get_done(input bit w8);
        return w8 ? bus8.done : bus32.done;
    endfunction

    function automatic logic get_busy(input bit w8);
        return w8 ? bus8.busy : bus32.busy;
    endfunction

    function automatic logic get_dbz(input bit w8);
        return w8 ? bus8.div_by_zero : bus32.div_by_zero;
    endfunction

    // Entered and left at #1 after a rising edge. lat = edges from accept to done,
    // -1 on timeout, -2 when aborted by reset at edge reset_at.
    task automatic div_op(input string tag, input bit w8, input bit sm,
                          input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input int reset_at,
                          output int lat, output logic [31:0] q, output logic [31:0] r,
                          output logic dbz, output logic [31:0] q_mid);
        drive(w8, 1'b1, sm, a, b);
        @(posedge clk); #1;
        drive(w8, 1'b0, sm, a, b);
        check_val({tag, " busy@E0"}, 64'(get_busy(w8)), 64'd1);
        check_val({tag, " dbz@E0"}, 64'(get_dbz(w8)), 64'd0);
        lat   = -1;
        q_mid = get_q(w8);
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            drive(w8, 1'b0, sm, a, b);
            if (n == poke_at) drive(w8, 1'b1, ~sm, a ^ 32'h5A5A_5A5A, 32'h0);
            if (n == 4) q_mid = get_q(w8);
            if (n == reset_at) begin
                clear = 1'b0;
                lat = -2;
                break;
            end
            if (get_done(w8)) begin
                lat = n;
                break;
            end
        end
        q   = get_q(w8);
        r   = get_r(w8);
        dbz = get_dbz(w8);
        $display("%s: W%0d %s 0x%0h / 0x%0h -> q=0x%0h r=0x%0h dbz=%0b lat=%0d",
                 tag, w8 ? 8 : 32, sm ? "signed" : "unsigned", a, b, q, r, dbz, lat);
    endtask

    task automatic idle_step(input string tag, input bit w8);
        @(posedge clk); #1;
        check_val({tag, " done pulse"}, 64'(get_done(w8)), 64'd0);
        check_val({tag, " busy idle"}, 64'(get_busy(w8)), 64'd0);
    endtask

    task automatic expect_result(input string tag, input int lat, input logic [31:0] q,
                                 input logic [31:0] r, input logic dbz, input int exp_lat,
                                 input logic [31:0] exp_q, input logic [31:0] exp_r,
                                 input logic exp_dbz);
        check_val({tag, " quotient"}, 64'(q), 64'(exp_q));
        check_val({tag, " remainder"}, 64'(r), 64'(exp_r));
        check_val({tag, " div_by_zero"}, 64'(dbz), 64'(exp_dbz));
        check_val({tag, " latency"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        int          lat;
        logic [31:0] q, r, q_mid;
        logic        dbz;

        clear = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_val("reset quotient", 64'(bus32.quotient), 64'd0);
        check_val("reset remainder", 64'(bus32.remainder), 64'd0);
        check_val("reset c_data_out", bus32.c_data_out, 64'd0);
        check_val("reset busy", 64'(bus32.busy), 64'd0);
        check_val("reset done", 64'(bus32.done), 64'd0);
        check_val("reset dbz", 64'(bus32.div_by_zero), 64'd0);
        clear = 1'b1;
        @(posedge clk); #1;

        div_op("T1", 1'b0, 1'b0, 32'h8000_0024, 32'h0000_0022, 0, 0, lat, q, r, dbz, q_mid);
        expect_result("T1", lat, q, r, dbz, 34, 32'h03C3_C3C4, 32'h0000_001C, 1'b0);
        check_val("T1 c_data_out", bus32.c_data_out, 64'h0000_001C_03C3_C3C4);
        idle_step("T1", 1'b0);

        div_op("T2a", 1'b0, 1'b1, 32'h8000_0024, 32'h0000_0022, 0, 0, lat, q, r, dbz, q_mid);
        expect_result("T2a", lat, q, r, dbz, 34, 32'hFC3C_3C3E, 32'hFFFF_FFE8, 1'b0);
        idle_step("T2a", 1'b0);

        div_op("T2b", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'h0000_0007, 0, 0, lat, q, r, dbz, q_mid);
        expect_result("T2b", lat, q, r, dbz, 34, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        idle_step("T2b", 1'b0);

        div_op("T3a", 1'b0, 1'b0, 32'h0000_1234, 32'h0000_0000, 0, 0, lat, q, r, dbz, q_mid);
        expect_result("T3a", lat, q, r, dbz, 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        idle_step("T3a", 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_val("T3a dbz held", 64'(bus32.div_by_zero), 64'd1);
        check_val("T3a q held", 64'(bus32.quotient), 64'hFFFF_FFFF);

        div_op("T3b", 1'b0, 1'b1, 32'h0000_1234, 32'h0000_0000, 0, 0, lat, q, r, dbz, q_mid);
        expect_result("T3b", lat, q, r, dbz, 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        idle_step("T3b", 1'b0);

        div_op("T4", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat, q, r, dbz, q_mid);
        expect_result("T4", lat, q, r, dbz, 34, 32'h8000_0000, 32'h0000_0000, 1'b0);
        idle_step("T4", 1'b0);

        // A second start mid-operation must not disturb the first.
        div_op("T5a", 1'b0, 1'b0, 32'h8000_0024, 32'h0000_0022, 10, 0, lat, q, r, dbz, q_mid);
        expect_result("T5a", lat, q, r, dbz, 34, 32'h03C3_C3C4, 32'h0000_001C, 1'b0);
        check_val("T5a q held mid-op", 64'(q_mid), 64'h8000_0000);
        idle_step("T5a", 1'b0);

        div_op("T5b", 1'b0, 1'b0, 32'd1000, 32'd10, 10, 20, lat, q, r, dbz, q_mid);
        check_val("T5b aborted", 64'(lat), 64'(-2));
        #1;
        check_val("T5b reset quotient", 64'(bus32.quotient), 64'd0);
        check_val("T5b reset remainder", 64'(bus32.remainder), 64'd0);
        check_val("T5b reset c_data_out", bus32.c_data_out, 64'd0);
        check_val("T5b reset busy", 64'(bus32.busy), 64'd0);
        check_val("T5b reset done", 64'(bus32.done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check_val("T5b busy after reset", 64'(bus32.busy), 64'd0);
        clear = 1'b1;

        div_op("T5c", 1'b0, 1'b0, 32'd100, 32'd7, 0, 0, lat, q, r, dbz, q_mid);
        expect_result("T5c", lat, q, r, dbz, 34, 32'd14, 32'd2, 1'b0);
        check_val("T5c q zero mid-op", 64'(q_mid), 64'd0);
        idle_step("T5c", 1'b0);

        div_op("T6a", 1'b1, 1'b0, 32'd200, 32'd3, 0, 0, lat, q, r, dbz, q_mid);
        expect_result("T6a", lat, q, r, dbz, 10, 32'd66, 32'd2, 1'b0);
        check_val("T6a c_data_out", 64'(bus8.c_data_out), 64'h0242);
        idle_step("T6a", 1'b1);

        div_op("T6b", 1'b1, 1'b0, 32'd100, 32'd7, 0, 0, lat, q, r, dbz, q_mid);
        expect_result("T6b", lat, q, r, dbz, 10, 32'd14, 32'd2, 1'b0);
        check_val("T6b q held mid-op", 64'(q_mid), 64'd66);
        idle_step("T6b", 1'b1);

        div_op("T6c", 1'b1, 1'b1, 32'h0000_009C, 32'd7, 0, 0, lat, q, r, dbz, q_mid);
        expect_result("T6c", lat, q, r, dbz, 10, 32'h0000_00F2, 32'h0000_00FE, 1'b0);
        idle_step("T6c", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
